// File: rtl/display_scan_4dig.sv
// Four-digit multiplexed seven-segment scan driver with a double-buffered frame and dead-time blanking.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_4dig #(
   parameter int DIV  = 10000,
   parameter int DEAD = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   input  logic        blank,
   output logic [7:0]  segmentos,
   output logic [3:0]  sel_seg,
   output logic        frame
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);

   logic [CW-1:0] cnt_r;
   logic [1:0]    idx_r;
   logic [15:0]   shadow_dig_r;
   logic [3:0]    shadow_dp_r;
   logic [15:0]   act_dig_r;
   logic [3:0]    act_dp_r;

   logic          wrap_s;
   logic [3:0]    dig_s;
   logic [3:0]    sel_s;
   logic          dp_s;
   logic          hide_s;
   logic [7:0]    seg_nxt_s;
   logic [3:0]    sel_nxt_s;
`ifdef DISPLAY_SCAN_LZB_EN
   logic [3:0]    lz_s;
`endif

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         4'hF: g = 7'h71;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   // Select the active digit for the current slot and form the next output values.
   always_comb begin
      wrap_s = (cnt_r == CNT_LAST);
      case (idx_r)
         2'd0: begin dig_s = act_dig_r[3:0];   sel_s = 4'b0001; end
         2'd1: begin dig_s = act_dig_r[7:4];   sel_s = 4'b0010; end
         2'd2: begin dig_s = act_dig_r[11:8];  sel_s = 4'b0100; end
         2'd3: begin dig_s = act_dig_r[15:12]; sel_s = 4'b1000; end
         default: begin dig_s = 4'h0; sel_s = 4'b0000; end
      endcase
      dp_s = act_dp_r[idx_r];
`ifdef DISPLAY_SCAN_LZB_EN
      // A digit is a leading zero only if it and every digit above it are zero; digit 0 always shows.
      lz_s[3] = (act_dig_r[15:12] == 4'h0);
      lz_s[2] = lz_s[3] && (act_dig_r[11:8] == 4'h0);
      lz_s[1] = lz_s[2] && (act_dig_r[7:4] == 4'h0);
      lz_s[0] = 1'b0;
      hide_s  = lz_s[idx_r];
`else
      hide_s  = 1'b0;
`endif
      if (blank || (cnt_r < CNT_DEAD)) begin
         seg_nxt_s = 8'h00;
         sel_nxt_s = 4'b0000;
      end else if (hide_s) begin
         seg_nxt_s = {dp_s, 7'h00};
         sel_nxt_s = dp_s ? sel_s : 4'b0000;
      end else begin
         seg_nxt_s = {dp_s, glyph(dig_s)};
         sel_nxt_s = sel_s;
      end
   end

   // Prescaler, slot index, shadow/active buffers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r        <= '0;
         idx_r        <= 2'd0;
         shadow_dig_r <= 16'h0000;
         shadow_dp_r  <= 4'h0;
         act_dig_r    <= 16'h0000;
         act_dp_r     <= 4'h0;
         segmentos    <= 8'h00;
         sel_seg      <= 4'b0000;
         frame        <= 1'b0;
      end else begin
         cnt_r <= wrap_s ? '0 : cnt_r + CW'(1);
         if (wrap_s) begin
            idx_r <= idx_r + 2'd1;
         end
         // Frame boundary takes the shadow as it stood before any same-cycle load.
         if (wrap_s && (idx_r == 2'd3)) begin
            act_dig_r <= shadow_dig_r;
            act_dp_r  <= shadow_dp_r;
         end
         if (load) begin
            shadow_dig_r <= digits_in;
            shadow_dp_r  <= dp_in;
         end
         segmentos <= seg_nxt_s;
         sel_seg   <= sel_nxt_s;
         frame     <= (cnt_r == '0) && (idx_r == 2'd0);
      end
   end

endmodule

// File: doc/display_scan_4dig.md
# display_scan_4dig

Four-digit multiplexed seven-segment scan driver that sits directly downstream of the counter in the display datapath. It takes a 16-bit hex/BCD value plus decimal points from the counter, double-buffers it so a frame is never torn, and time-multiplexes it onto a shared 8-bit segment bus with a one-hot digit select. A dead time between digit slots suppresses ghosting. Its outputs drive `segmentos` and `sel_seg` in the top-level wrapper.

## Interface
- `DIV`, default 10000: clock cycles per digit slot; legal range ≥ `DEAD`+2.
- `DEAD`, default 16: blanked cycles at the start of each slot; legal range ≥ 1.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `digits_in` in 16: digit 3 in [15:12] down to digit 0 in [3:0]; digit 0 is rightmost.
- `dp_in` in 4: decimal point per digit; bit i belongs to digit i.
- `load` in 1: single-cycle strobe; captures `digits_in` and `dp_in` into the shadow register.
- `blank` in 1: level; forces `sel_seg` to 0 while high.
- `segmentos` out 8: active-high; bit 7 = dp; bits 6:0 = segments g..a, with a in bit 0.
- `sel_seg` out 4: one-hot active-high digit enable; bit i enables digit i.
- `frame` out 1: one-cycle pulse when the digit-0 slot begins.

## Operation
- Prescaler `cnt` counts 0..`DIV`-1 and wraps. On wrap, slot index `idx` advances 0→1→2→3→0.
- Shadow register: written on any cycle with `load`=1. A later `load` overwrites an earlier one; no handshake exists and no load is ever refused.
- Active register: copied from the shadow when `cnt` wraps with `idx`=3, which is the frame boundary.
- If `load` and the frame boundary fall in the same cycle, the active register takes the pre-load shadow contents. The new value is shown from the next frame.
- Glyph decode, hex values 0..F as segment bits 6:0: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- `segmentos[7]` = `dp` of the active digit.
- During `cnt` < `DEAD`, both `sel_seg` and `segmentos` are 0.
- During `cnt` ≥ `DEAD`, `sel_seg` = 1<<`idx` and `segmentos` shows the active digit `idx`.
- `blank`=1 forces `sel_seg`=0 and `segmentos`=0. Scanning, the prescaler and buffering continue unchanged underneath.
- Reset values: `cnt`=0, `idx`=0, shadow=0, active=0, `segmentos`=0, `sel_seg`=0, `frame`=0. Reset mid-slot aborts the slot immediately and discards any pending shadow value.

## Timing
- All outputs are registered. Each output reflects the `cnt`/`idx`/active state of the previous cycle.
- Counting from the first edge with `rst` low as edge 1:
  - `sel_seg` becomes 0001 after edge `DEAD`+1.
  - It holds for `DIV`-`DEAD` cycles, then reads 0000 for `DEAD` cycles, then 0010, and so on.
- Frame period is 4·`DIV` cycles.
- `frame` rises after the edge on which the digit-0 slot starts (`cnt`=0, `idx`=0), lasts one cycle, and repeats every 4·`DIV` cycles.
- Load-to-display latency:
  - Minimum is 1 cycle to the frame boundary, plus `DEAD`+1 cycles to the first lit digit.
  - Maximum is 4·`DIV` cycles plus `DEAD`+1 cycles.
- `blank` takes effect on outputs one cycle after it changes.

## Configuration
- Macro: `DISPLAY_SCAN_LZB_EN`.
- When defined, leading-zero blanking is on:
  - Digit i (i = 3..1) is blanked when it and every more-significant active digit equal 0. Blanked means segments 6:0 are 0 and `sel_seg` stays 0 for that slot.
  - Its dp still lights if set; in that case `sel_seg` is asserted with segments 6:0 = 0.
  - Digit 0 is never blanked.
- When undefined, every digit is always shown, including leading zeros.

## Test plan
All scenarios use `DIV`=8 and `DEAD`=2.
- Reset then release with shadow 0 → `sel_seg` is 0001 from edge 3 through edge 8 and 0000 at edges 9–10. `segmentos`=3F whenever `sel_seg`≠0. `frame` pulses every 32 cycles.
- `load` with `digits_in`=0x12AF, `dp_in`=0100 → from the next frame, slots show:
  - digit 0 = 71
  - digit 1 = 77
  - digit 2 = DB (dp set)
  - digit 3 = 06
- `load` in the same cycle as the frame boundary → the old value is displayed for one more full frame, and the new value appears at the following `frame`.
- Two `load`s in one frame (0x1111, then 0x2222) → next frame shows 0x2222 only; glyph 06 is never output for that frame.
- `blank`=1 for 20 cycles mid-frame → `sel_seg`=0 and `segmentos`=0 during those cycles. `frame` spacing remains 32 cycles.
- With `DISPLAY_SCAN_LZB_EN` defined, `digits_in`=0x0050 → digit 3 slot has `sel_seg`=0, digit 2 slot has `sel_seg`=0, digit 1 shows 6D, digit 0 shows 3F. Without the macro, digits 3 and 2 show 3F.
- `rst` asserted mid-slot → outputs are 0 on the next cycle, and after release the scan restarts from digit 0 with blank shadow and active registers.
